// File: rtl/stage_fifo_bus.sv
// stage_fifo_bus: DEPTH-entry circular buffer carrying WIDTH-bit stage payloads
// between two pipeline stages (or IFU -> decode as a fetch queue). It is a
// valid/ready stage bus extended with a synchronous flush for redirects, an
// optional combinational m_ready -> s_ready path, and an occupancy count.
module stage_fifo_bus #(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int PIPE_READY = 0,
    localparam int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    // Pointers need at least one bit even when DEPTH is 1.
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // Status flags come straight from the registered count, so they are
    // glitch-free and known as soon as reset is applied.
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign m_valid = ~empty;

    // With PIPE_READY a full buffer still accepts when the head leaves in
    // the same cycle; otherwise s_ready depends only on stored state.
    generate
        if (PIPE_READY != 0) begin : g_pipe_ready
            assign s_ready = ~full | m_ready;
        end else begin : g_reg_ready
            assign s_ready = ~full;
        end
    endgenerate

    assign push   = s_valid & s_ready;
    assign pop    = m_valid & m_ready;
    assign m_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush wins over any handshake in
    // the same cycle and leaves the buffer empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Payload storage is deliberately not reset; a push dropped by flush
    // never becomes visible because the pointers are cleared alongside.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= s_data;
        end
    end

endmodule

// File: tb/tb_stage_fifo_bus.sv
// tb_stage_fifo_bus: drives five differently parametrised stage_fifo_bus
// instances from one shared set of inputs and compares each against an
// array-backed queue model of its contents.
module tb_stage_fifo_bus;

    localparam int NI = 5;

    // Instance configurations: 0:(3,0) 1:(2,1) 2:(4,0) 3:(1,0) 4:(1,1)
    function automatic int dep_of(input int i);
        case (i)
            0:       return 3;
            1:       return 2;
            2:       return 4;
            default: return 1;
        endcase
    endfunction

    function automatic bit pr_of(input int i);
        return (i == 1) || (i == 4);
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        m_ready;
    logic [31:0] s_data;

    logic        mv [NI];
    logic        sr [NI];
    logic        fu [NI];
    logic        em [NI];
    logic [31:0] md [NI];
    logic [2:0]  cnt [NI];

    // Reference model: entries in arrival order, head at index 0.
    logic [31:0] qm [NI][8];
    int          qn [NI];

    int npass  = 0;
    int ntotal = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int D  = dep_of(g);
        localparam int CW = $clog2(D + 1);
        logic [CW-1:0] c;
        logic          v;
        logic          r;
        logic          f;
        logic          e;
        logic [31:0]   d;

        stage_fifo_bus #(
            .WIDTH(32),
            .DEPTH(D),
            .PIPE_READY(pr_of(g) ? 1 : 0)
        ) dut (
            .clk(clk),
            .rst(rst),
            .flush(flush),
            .s_valid(s_valid),
            .s_ready(r),
            .s_data(s_data),
            .m_valid(v),
            .m_ready(m_ready),
            .m_data(d),
            .count(c),
            .full(f),
            .empty(e)
        );

        assign cnt[g] = 3'(c);
        assign mv[g]  = v;
        assign sr[g]  = r;
        assign fu[g]  = f;
        assign em[g]  = e;
        assign md[g]  = d;
    end

    function automatic bit exp_ready(input int i);
        return (qn[i] < dep_of(i)) || (pr_of(i) && m_ready);
    endfunction

    // Advance one clock: decide handshakes from the model, apply them at the
    // edge, and return at the following falling edge.
    task automatic tick();
        bit pu [NI];
        bit po [NI];
        for (int i = 0; i < NI; i++) begin
            pu[i] = s_valid && exp_ready(i);
            po[i] = (qn[i] > 0) && m_ready;
        end
        @(posedge clk);
        for (int i = 0; i < NI; i++) begin
            if (flush) begin
                qn[i] = 0;
            end else begin
                if (po[i]) begin
                    for (int j = 0; j < 7; j++) qm[i][j] = qm[i][j + 1];
                    qn[i]--;
                end
                if (pu[i]) begin
                    qm[i][qn[i]] = s_data;
                    qn[i]++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (6) tick();
        m_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
        for (int i = 0; i < NI; i++) qn[i] = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            ntotal++;
            if (mv[i] !== 1'b0 || sr[i] !== 1'b1 || cnt[i] !== 3'd0 || em[i] !== 1'b1 || fu[i] !== 1'b0)
                $display("[TB] FAIL reset_state inst=%0d got mv=%b sr=%b cnt=%0d em=%b fu=%b exp 0 1 0 1 0",
                         i, mv[i], sr[i], cnt[i], em[i], fu[i]);
            else npass++;
        end
        rst = 1'b1;
        s_valid = 1'b1; s_data = 32'hDEADBEEF;
        #1 tick();
        s_valid = 1'b0;
        #1;
        ntotal++;
        if (mv[0] !== 1'b1 || md[0] !== 32'hDEADBEEF)
            $display("[TB] FAIL first_push got mv=%b data=%h exp mv=1 data=deadbeef", mv[0], md[0]);
        else npass++;
        drain();
    endtask

    task automatic test_fill_wrap();
        logic [31:0] exp_seq [4];
        int k;
        exp_seq[0] = 32'd1; exp_seq[1] = 32'd2; exp_seq[2] = 32'd3; exp_seq[3] = 32'd4;
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int v = 1; v <= 3; v++) begin
            s_data = 32'(v);
            #1 tick();
        end
        s_data = 32'd4;
        #1;
        ntotal++;
        if (cnt[0] !== 3'd3 || fu[0] !== 1'b1 || sr[0] !== 1'b0)
            $display("[TB] FAIL fill_full got cnt=%0d full=%b s_ready=%b exp 3 1 0", cnt[0], fu[0], sr[0]);
        else npass++;
        tick();
        #1;
        ntotal++;
        if (cnt[0] !== 3'd3 || md[0] !== 32'd1)
            $display("[TB] FAIL fill_hold got cnt=%0d head=%h exp 3 00000001", cnt[0], md[0]);
        else npass++;
        m_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (mv[0] === 1'b1 && k < 4) begin
                ntotal++;
                if (md[0] !== exp_seq[k])
                    $display("[TB] FAIL wrap_order idx=%0d got=%h exp=%h", k, md[0], exp_seq[k]);
                else npass++;
                k++;
            end
            if (s_valid && sr[0]) begin
                tick();
                s_valid = 1'b0;
            end else begin
                tick();
            end
        end
        #1;
        ntotal++;
        if (k !== 4 || cnt[0] !== 3'd0 || em[0] !== 1'b1)
            $display("[TB] FAIL wrap_drain got outputs=%0d cnt=%0d empty=%b exp 4 0 1", k, cnt[0], em[0]);
        else npass++;
        drain();
    endtask

    task automatic test_pipe_ready();
        logic [31:0] e;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 32'hA0; #1 tick();
        s_data = 32'hA1; #1 tick();
        #1;
        ntotal++;
        if (cnt[1] !== 3'd2 || fu[1] !== 1'b1)
            $display("[TB] FAIL pipe_fill got cnt=%0d full=%b exp 2 1", cnt[1], fu[1]);
        else npass++;
        m_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 32'(10 + k);
            e = (k < 2) ? 32'(32'hA0 + k) : 32'(10 + k - 2);
            #1;
            ntotal++;
            if (sr[1] !== 1'b1 || mv[1] !== 1'b1 || md[1] !== e || cnt[1] !== 3'd2)
                $display("[TB] FAIL pipe_stream cyc=%0d got sr=%b mv=%b data=%h cnt=%0d exp 1 1 %h 2",
                         k, sr[1], mv[1], md[1], cnt[1], e);
            else npass++;
            tick();
        end
        drain();
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        s_valid = 1'b1;
        for (int v = 0; v < 3; v++) begin
            s_data = 32'(32'h31 + v);
            #1 tick();
        end
        #1;
        ntotal++;
        if (cnt[2] !== 3'd3)
            $display("[TB] FAIL flush_prefill got cnt=%0d exp 3", cnt[2]);
        else npass++;
        s_data = 32'h55; m_ready = 1'b1; flush = 1'b1;
        #1;
        ntotal++;
        if (sr[2] !== 1'b1)
            $display("[TB] FAIL flush_sready got=%b exp=1", sr[2]);
        else npass++;
        tick();
        flush = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        #1;
        ntotal++;
        if (cnt[2] !== 3'd0 || em[2] !== 1'b1 || mv[2] !== 1'b0)
            $display("[TB] FAIL flush_clear got cnt=%0d empty=%b mv=%b exp 0 1 0", cnt[2], em[2], mv[2]);
        else npass++;
        s_valid = 1'b1; s_data = 32'h66;
        #1 tick();
        s_valid = 1'b0;
        #1;
        ntotal++;
        if (mv[2] !== 1'b1 || md[2] !== 32'h66 || cnt[2] !== 3'd1)
            $display("[TB] FAIL flush_after got mv=%b data=%h cnt=%0d exp 1 00000066 1", mv[2], md[2], cnt[2]);
        else npass++;
        m_ready = 1'b1;
        #1 tick();
        #1;
        ntotal++;
        if (mv[2] !== 1'b0)
            $display("[TB] FAIL flush_no55 got mv=%b data=%h exp mv=0", mv[2], md[2]);
        else npass++;
        drain();
    endtask

    task automatic test_throughput();
        logic [31:0] next_d;
        // Single-entry, registered ready: accepts every other cycle.
        m_ready = 1'b1;
        s_valid = 1'b1;
        next_d = 32'h70;
        s_data = next_d;
        for (int k = 0; k < 8; k++) begin
            #1;
            ntotal++;
            if (sr[3] !== ((k % 2) == 0) || mv[3] !== ((k % 2) == 1) ||
                (mv[3] === 1'b1 && md[3] !== 32'(32'h70 + (k - 1) / 2)))
                $display("[TB] FAIL d1_half cyc=%0d got sr=%b mv=%b data=%h exp sr=%0d mv=%0d data=%h",
                         k, sr[3], mv[3], md[3], (k % 2) == 0, (k % 2) == 1, 32'(32'h70 + (k - 1) / 2));
            else npass++;
            if (sr[3]) begin
                tick();
                next_d++;
                s_data = next_d;
            end else begin
                tick();
            end
        end
        drain();
        // Single-entry, pass-through ready: accepts every cycle.
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            s_data = 32'(32'h80 + k);
            #1;
            ntotal++;
            if (sr[4] !== 1'b1 || mv[4] !== (k >= 1) || (k >= 1 && md[4] !== 32'(32'h80 + k - 1)))
                $display("[TB] FAIL d1_full cyc=%0d got sr=%b mv=%b data=%h exp sr=1 mv=%0d data=%h",
                         k, sr[4], mv[4], md[4], k >= 1, 32'(32'h80 + k - 1));
            else npass++;
            tick();
        end
        drain();
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = 32'h11; #1 tick();
        s_data = 32'h12; #1 tick();
        s_valid = 1'b0;
        #1;
        ntotal++;
        if (cnt[0] !== 3'd2 || mv[0] !== 1'b1)
            $display("[TB] FAIL areset_pre got cnt=%0d mv=%b exp 2 1", cnt[0], mv[0]);
        else npass++;
        #1 rst = 1'b0;
        #1;
        ntotal++;
        if (mv[0] !== 1'b0 || cnt[0] !== 3'd0 || em[0] !== 1'b1 || sr[0] !== 1'b1)
            $display("[TB] FAIL areset_async got mv=%b cnt=%0d empty=%b sr=%b exp 0 0 1 1",
                     mv[0], cnt[0], em[0], sr[0]);
        else npass++;
        for (int i = 0; i < NI; i++) qn[i] = 0;
        @(negedge clk);
        rst = 1'b1;
        s_valid = 1'b1; s_data = 32'hC0FFEE01;
        #1 tick();
        s_valid = 1'b0;
        #1;
        ntotal++;
        if (mv[0] !== 1'b1 || md[0] !== 32'hC0FFEE01 || cnt[0] !== 3'd1)
            $display("[TB] FAIL areset_after got mv=%b data=%h cnt=%0d exp 1 c0ffee01 1", mv[0], md[0], cnt[0]);
        else npass++;
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            s_valid = 1'($urandom_range(0, 3) != 0);
            m_ready = 1'($urandom_range(0, 2) != 0);
            flush   = 1'($urandom_range(0, 24) == 0);
            s_data  = $urandom;
            #1;
            for (int i = 0; i < NI; i++) begin
                ntotal++;
                if (mv[i] !== (qn[i] > 0) || sr[i] !== exp_ready(i) || cnt[i] !== 3'(qn[i]) ||
                    fu[i] !== (qn[i] == dep_of(i)) || em[i] !== (qn[i] == 0))
                    $display("[TB] FAIL rand_status cyc=%0d inst=%0d got mv=%b sr=%b cnt=%0d fu=%b em=%b exp cnt=%0d sr=%b",
                             c, i, mv[i], sr[i], cnt[i], fu[i], em[i], qn[i], exp_ready(i));
                else npass++;
                if (qn[i] > 0) begin
                    ntotal++;
                    if (md[i] !== qm[i][0])
                        $display("[TB] FAIL rand_data cyc=%0d inst=%0d got=%h exp=%h", c, i, md[i], qm[i][0]);
                    else npass++;
                end
            end
            tick();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_fill_wrap();
        test_pipe_ready();
        test_flush();
        test_throughput();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
